// File: rtl/msg_compose_pkg.sv
// -----------------------------------------------------------------------------
// msg_compose_pkg
// Shared definitions for the message composer: FSM state encoding, the ASCII
// control codes the editor reacts to, frame geometry and a printable-range
// helper.
// -----------------------------------------------------------------------------
package msg_compose_pkg;

    // Composer states
    typedef enum logic [1:0] {
        EDIT  = 2'd0,
        SEND  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // ASCII codes with special meaning to the editor
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_FIRST = 8'h20;
    localparam logic [7:0] ASCII_LAST  = 8'h7E;

    // Frame geometry
    localparam int          MSG_CHARS = 16;
    localparam int          MSG_BITS  = MSG_CHARS * 8;
    localparam logic [4:0]  CNT_FULL  = 5'd16;
    localparam logic [4:0]  CNT_ZERO  = 5'd0;

    // A frame with every character slot blank
    localparam logic [MSG_BITS-1:0] MSG_BLANK = {MSG_CHARS{ASCII_SPACE}};

    // True for codes that are stored as characters (space through tilde)
    function automatic logic is_printable(input logic [7:0] code);
        return (code >= ASCII_FIRST) && (code <= ASCII_LAST);
    endfunction

endpackage

// File: rtl/msg_compose_edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for a level input. Produces a pulse in the cycle where
// the level is first seen high after having been seen low.
//
// Ports:
//   i_clk    in   clock, rising edge
//   i_rst_n  in   synchronous active-low reset
//   i_level  in   level to watch
//   o_pulse  out  high for the first cycle of each high period
//
// The pulse is combinational from the input and the registered previous level
// so that the consumer can act on the very edge that first samples the level
// high. A level that is already high while reset is asserted is masked until
// it drops, so releasing reset never fabricates an edge.
// -----------------------------------------------------------------------------
module edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;
    logic r_block;

    // Previous-level history and post-reset masking of an already-high level
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_block <= i_level;
        end else begin
            r_prev  <= i_level;
            r_block <= r_block & i_level;
        end
    end

    assign o_pulse = i_level & ~r_prev & ~r_block;

endmodule

// File: rtl/msg_compose.sv
// -----------------------------------------------------------------------------
// msg_compose
// Keyboard-driven 16-character message editor with a send handshake toward a
// GPIO transport link.
//
// Ports:
//   clock       in   system clock, rising edge
//   resetn      in   synchronous active-low reset
//   key_valid   in   keyboard byte-available level (may stay high many cycles)
//   key_ascii   in   [7:0] ASCII of the current key
//   enable      in   editing allowed (display in sending state)
//   send_done   in   transport completion level
//   message     out  [127:0] frame, char i in bits [8i+7:8i]
//   char_count  out  [4:0] characters entered, 0..16
//   msg_ready   out  request to transport, high only while sending
//   send_err    out  one-cycle pulse when a send times out
//   full        out  char_count == 16
//
// Editing: printable keys append, BS removes the last character (slot goes
// back to space), CR with a non-empty frame starts a send. While sending,
// the frame is frozen and keys are discarded; send_done clears the frame via
// a one-cycle CLEAR state, and a timeout returns to editing with the frame
// kept and send_err pulsed. send_done wins over a simultaneous timeout.
// -----------------------------------------------------------------------------
module msg_compose
    import msg_compose_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         key_valid,
    input  logic [7:0]   key_ascii,
    input  logic         enable,
    input  logic         send_done,
    output logic [127:0] message,
    output logic [4:0]   char_count,
    output logic         msg_ready,
    output logic         send_err,
    output logic         full
);

    // Timer only needs to reach TIMEOUT_CYCLES-1
    localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    state_t               r_state;
    logic [MSG_BITS-1:0]  r_message;
    logic [4:0]           r_count;
    logic [TW-1:0]        r_timer;
    logic                 r_msg_ready;
    logic                 r_send_err;
    logic                 r_full;

    state_t               w_state_n;
    logic [MSG_BITS-1:0]  w_message_n;
    logic [4:0]           w_count_n;
    logic [TW-1:0]        w_timer_n;
    logic                 w_msg_ready_n;
    logic                 w_send_err_n;
    logic                 w_full_n;

    logic                 w_key_event;
    logic [6:0]           w_wr_bit;
    logic [6:0]           w_bs_bit;
    logic [3:0]           w_last_idx;

    edge_detect u_key_edge (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_level (key_valid),
        .o_pulse (w_key_event)
    );

    // Bit offsets of the append slot and of the slot vacated by backspace.
    // At count 16 the low nibble wraps to 0, so the backspace slot is 15.
    assign w_last_idx = r_count[3:0] - 4'd1;
    assign w_wr_bit   = {r_count[3:0], 3'b000};
    assign w_bs_bit   = {w_last_idx, 3'b000};

    // Next-state and next-output logic for the composer FSM
    always_comb begin
        w_state_n    = r_state;
        w_message_n  = r_message;
        w_count_n    = r_count;
        w_timer_n    = r_timer;
        w_send_err_n = 1'b0;

        case (r_state)
            EDIT: begin
                w_timer_n = TIMER_ZERO;
                if (w_key_event && enable) begin
                    if (is_printable(key_ascii)) begin
                        if (r_count < CNT_FULL) begin
                            w_message_n[w_wr_bit +: 8] = key_ascii;
                            w_count_n                  = r_count + 5'd1;
                        end else begin
                            w_count_n = r_count;
                        end
                    end else if (key_ascii == ASCII_BS) begin
                        if (r_count != CNT_ZERO) begin
                            w_message_n[w_bs_bit +: 8] = ASCII_SPACE;
                            w_count_n                  = r_count - 5'd1;
                        end else begin
                            w_count_n = r_count;
                        end
                    end else if (key_ascii == ASCII_CR) begin
                        if (r_count != CNT_ZERO) begin
                            w_state_n = SEND;
                        end else begin
                            w_state_n = EDIT;
                        end
                    end else begin
                        w_state_n = EDIT;
                    end
                end else begin
                    w_state_n = EDIT;
                end
            end

            SEND: begin
                // Completion is checked before the timeout so it wins a tie
                if (send_done) begin
                    w_state_n = CLEAR;
                    w_timer_n = TIMER_ZERO;
                end else if (r_timer == TIMER_LAST) begin
                    w_state_n    = EDIT;
                    w_timer_n    = TIMER_ZERO;
                    w_send_err_n = 1'b1;
                end else begin
                    w_timer_n = r_timer + TIMER_ONE;
                end
            end

            CLEAR: begin
                w_state_n   = EDIT;
                w_message_n = MSG_BLANK;
                w_count_n   = CNT_ZERO;
                w_timer_n   = TIMER_ZERO;
            end

            default: begin
                // Unreachable encoding: recover to an empty editor
                w_state_n   = EDIT;
                w_message_n = MSG_BLANK;
                w_count_n   = CNT_ZERO;
                w_timer_n   = TIMER_ZERO;
            end
        endcase

        w_msg_ready_n = (w_state_n == SEND);
        w_full_n      = (w_count_n == CNT_FULL);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= EDIT;
            r_message   <= MSG_BLANK;
            r_count     <= CNT_ZERO;
            r_timer     <= TIMER_ZERO;
            r_msg_ready <= 1'b0;
            r_send_err  <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_message   <= w_message_n;
            r_count     <= w_count_n;
            r_timer     <= w_timer_n;
            r_msg_ready <= w_msg_ready_n;
            r_send_err  <= w_send_err_n;
            r_full      <= w_full_n;
        end
    end

    assign message    = r_message;
    assign char_count = r_count;
    assign msg_ready  = r_msg_ready;
    assign send_err   = r_send_err;
    assign full       = r_full;

endmodule

// File: tb/tb_msg_compose.sv
// -----------------------------------------------------------------------------
// tb_msg_compose
// Directed and randomized bench for msg_compose (TIMEOUT_CYCLES = 8). The
// reference keeps the typed text as a byte queue and a "sending" flag; the
// expected frame is the queue contents padded with spaces.
// -----------------------------------------------------------------------------
module tb_msg_compose;

    logic         clock;
    logic         resetn;
    logic         key_valid;
    logic [7:0]   key_ascii;
    logic         enable;
    logic         send_done;
    logic [127:0] message;
    logic [4:0]   char_count;
    logic         msg_ready;
    logic         send_err;
    logic         full;

    int n_cmp;
    int n_err;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_send;

    msg_compose #(.TIMEOUT_CYCLES(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .key_valid  (key_valid),
        .key_ascii  (key_ascii),
        .enable     (enable),
        .send_done  (send_done),
        .message    (message),
        .char_count (char_count),
        .msg_ready  (msg_ready),
        .send_err   (send_err),
        .full       (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_msg();
        logic [127:0] e;
        for (int i = 0; i < 16; i++)
            e[i*8 +: 8] = (i < m_q.size()) ? m_q[i] : 8'h20;
        return e;
    endfunction

    // Editing rules applied to one key event
    function automatic void model_key(input logic [7:0] ch, input logic en);
        if (m_send || !en) return;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            if (m_q.size() < 16) m_q.push_back(ch);
        end else if (ch == 8'h08) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (ch == 8'h0D) begin
            if (m_q.size() > 0) m_send = 1'b1;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".msg"},   message, exp_msg());
        chk({tag, ".cnt"},   128'(char_count), 128'(m_q.size()));
        chk({tag, ".full"},  128'(full), 128'(m_q.size() == 16));
        chk({tag, ".ready"}, 128'(msg_ready), 128'(m_send));
        chk({tag, ".err"},   128'(send_err), 128'(0));
    endtask

    // One key: level held for 'hold' cycles, then one low cycle
    task automatic press(input logic [7:0] ch, input int hold);
        model_key(ch, enable);
        key_ascii = ch;
        key_valid = 1'b1;
        tick(hold);
        key_valid = 1'b0;
        tick(1);
    endtask

    // Completes a send already entered by a CR press (timer now at 1)
    task automatic finish_send(input string tag);
        int w;
        logic en_save;
        w = $urandom_range(0, 3);
        check_all({tag, ".in_send"});
        en_save = enable;
        enable  = 1'($urandom_range(0, 1));
        press(8'($urandom_range(32'h41, 32'h5A)), 1);
        enable  = en_save;
        tick(w);
        check_all({tag, ".frozen"});
        send_done = 1'b1;
        tick(1);
        send_done = 1'b0;
        chk({tag, ".ready_drop"}, 128'(msg_ready), 128'(0));
        chk({tag, ".no_err"},     128'(send_err), 128'(0));
        tick(1);
        m_q.delete();
        m_send = 1'b0;
        check_all({tag, ".cleared"});
    endtask

    initial begin
        logic [7:0] ch;
        int         sel;
        logic [127:0] snap;

        n_cmp = 0;
        n_err = 0;
        m_send = 1'b0;
        resetn = 1'b0;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        enable = 1'b1;
        send_done = 1'b0;

        // Reset values
        tick(3);
        check_all("reset");
        resetn = 1'b1;
        tick(1);
        check_all("post_reset");

        // "Hi" then CR, send_done a few cycles later
        press(8'h48, 1);
        press(8'h69, 2);
        press(8'h0D, 1);
        chk("hi.low16", 128'(message[15:0]), 128'(16'h6948));
        check_all("hi.send");
        tick(1);
        send_done = 1'b1;
        tick(1);
        send_done = 1'b0;
        chk("hi.ready_drop", 128'(msg_ready), 128'(0));
        tick(1);
        m_q.delete();
        m_send = 1'b0;
        check_all("hi.cleared");

        // Long key_valid high period yields exactly one character
        press(8'h41, 40);
        chk("hold.byte0", 128'(message[7:0]), 128'(8'h41));
        check_all("hold");

        // BS to empty, then BS/CR at count 0 and keys with enable low
        press(8'h08, 1);
        check_all("bs_to_zero");
        press(8'h08, 2);
        press(8'h0D, 1);
        check_all("bs_cr_empty");
        enable = 1'b0;
        press(8'h42, 1);
        press(8'h0D, 1);
        enable = 1'b1;
        check_all("enable_low");
        send_done = 1'b1;
        tick(1);
        send_done = 1'b0;
        check_all("done_in_edit");

        // Fill beyond capacity, then backspace from full
        for (int i = 0; i < 17; i++)
            press(8'($urandom_range(32'h20, 32'h7E)), 1);
        chk("full.flag", 128'(full), 128'(1));
        check_all("full17");
        press(8'h08, 1);
        chk("full.slot15", 128'(message[127:120]), 128'(8'h20));
        check_all("full_bs");
        press(8'h0D, 1);
        finish_send("full_send");

        // Timeout: 3 chars, CR, no send_done
        press(8'h61, 1);
        press(8'h62, 1);
        press(8'h63, 1);
        snap = exp_msg();
        press(8'h0D, 1);
        tick(6);
        check_all("to.before");
        tick(1);
        chk("to.err_pulse", 128'(send_err), 128'(1));
        chk("to.ready", 128'(msg_ready), 128'(0));
        chk("to.msg_kept", message, snap);
        chk("to.cnt_kept", 128'(char_count), 128'(3));
        m_send = 1'b0;
        tick(1);
        check_all("to.after");
        press(8'h64, 1);
        check_all("to.edit_again");

        // send_done on the same cycle the timeout would fire
        press(8'h0D, 1);
        tick(6);
        send_done = 1'b1;
        tick(1);
        send_done = 1'b0;
        chk("tie.ready", 128'(msg_ready), 128'(0));
        chk("tie.no_err", 128'(send_err), 128'(0));
        tick(1);
        m_q.delete();
        m_send = 1'b0;
        check_all("tie.cleared");

        // Randomized editing with occasional sends
        for (int it = 0; it < 150; it++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) begin
                send_done = 1'b1;
                tick(1);
                send_done = 1'b0;
            end
            sel = $urandom_range(0, 99);
            if (sel < 60)      ch = 8'($urandom_range(32'h20, 32'h7E));
            else if (sel < 75) ch = 8'h08;
            else if (sel < 85) ch = 8'($urandom_range(32'h7F, 32'hFF));
            else if (sel < 90) ch = 8'($urandom_range(32'h00, 32'h07));
            else               ch = 8'h0D;
            if (ch == 8'h0D) press(ch, 1);
            else             press(ch, $urandom_range(1, 4));
            if (m_send) finish_send("rnd_send");
            else        check_all("rnd");
        end
        enable = 1'b1;

        // Reset during SEND with key_valid held high across release
        press(8'h58, 1);
        press(8'h0D, 1);
        check_all("rst.in_send");
        key_ascii = 8'h5A;
        key_valid = 1'b1;
        resetn = 1'b0;
        tick(2);
        m_q.delete();
        m_send = 1'b0;
        check_all("rst.asserted");
        resetn = 1'b1;
        tick(3);
        check_all("rst.released");
        key_valid = 1'b0;
        tick(1);
        check_all("rst.key_low");
        press(8'h51, 1);
        check_all("rst.typing");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/msg_compose.md
MSG_COMPOSE -- requirements
Module: msg_compose

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50_000_000: SEND-state cycles allowed before abort (1 s at 50 MHz).
REQ-002 clock  in  1  single system clock; all logic on its rising edge.
REQ-003 resetn  in  1  reset, synchronous and active-low.
REQ-004 key_valid  in  1  keyboard byte-available level; may stay high many cycles per key.
REQ-005 key_ascii  in  8  ASCII of current key; sampled only on key_valid rising edge.
REQ-006 enable  in  1  high while the display is in sending state; gates editing.
REQ-007 send_done  in  1  transport completion level from the GPIO link.
REQ-008 message  out  128  16-char frame; char i in bits [8i+7:8i], char 0 in [7:0].
REQ-009 char_count  out  5  characters entered, 0..16.
REQ-010 msg_ready  out  1  level request to transport; high only in SEND.
REQ-011 send_err  out  1  one-cycle pulse on send timeout.
REQ-012 full  out  1  high when char_count == 16.

Function
REQ-013 Key event = key_valid high this cycle and low the previous cycle (one registered delay stage); exactly one event per key_valid high period.
REQ-014 States: EDIT, SEND, CLEAR; FSM and all outputs registered; an event is applied on the same edge that first samples key_valid=1.
REQ-015 EDIT, enable=1, event, key_ascii 0x20..0x7E, char_count<16: write byte at index char_count, char_count+1.
REQ-016 EDIT printable event with char_count==16: dropped, no state change.
REQ-017 EDIT event 0x08 (backspace), char_count>0: char_count-1, vacated slot set to 0x20; char_count==0: no-op.
REQ-018 EDIT event 0x0D (enter), char_count>0: go SEND; char_count==0: ignored.
REQ-019 All other codes, and any event with enable=0, ignored; message and char_count held.
REQ-020 SEND: msg_ready=1, message frozen, all key events discarded, enable ignored.
REQ-021 SEND and send_done sampled 1: go CLEAR next edge; msg_ready low from that edge.
REQ-022 CLEAR (exactly one cycle): message all 0x20, char_count 0, then EDIT.
REQ-023 SEND timeout counter starts at 0 on SEND entry; at TIMEOUT_CYCLES-1 without send_done: go EDIT, message and char_count kept, send_err pulses one cycle.
REQ-024 send_done and timeout in the same cycle: send_done wins, no send_err.
REQ-025 send_done outside SEND: ignored.
REQ-026 full = (char_count == 16), registered.

Reset
REQ-027 resetn sampled 0: state EDIT, message all 0x20, char_count 0, msg_ready 0, send_err 0, full 0, timeout counter 0, edge register 0.
REQ-028 Reset mid-SEND aborts without send_err; a key_valid already high when reset releases does not generate an event.

Structure
REQ-029 Shared package holds state encoding (EDIT, SEND, CLEAR), ASCII constants SPACE 0x20, BS 0x08, CR 0x0D, and MSG_CHARS = 16.
REQ-030 One sub-module, edge_detect (rising-edge pulse with synchronous active-low reset), used for key_valid.

Verification
REQ-031 Keys 'H'(0x48), 'i'(0x69), CR; send_done 3 cycles later -> message[15:0]=0x6948, char_count=2, msg_ready=1 until send_done, then all 0x20, count 0.
REQ-032 key_valid held high 40 cycles with 'A' -> exactly one 0x41 written, char_count=1.
REQ-033 17 printable keys -> first 16 stored, full=1, 17th dropped; BS -> count 15, byte 15 = 0x20, full=0.
REQ-034 TIMEOUT_CYCLES=8, CR with count 3, no send_done -> send_err one pulse 8 cycles after SEND entry, state EDIT, message unchanged.
REQ-035 BS and CR at count 0, plus keys with enable=0 -> no output change; resetn low during SEND -> all reset values, no send_err.
